// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide mode-0 SPI master shift engine.
package spi_pkg;

  localparam int unsigned DIV_W_DEFAULT  = 8;
  localparam int unsigned EDGES_PER_BYTE = 16;
  localparam int unsigned EDGE_W         = $clog2(EDGES_PER_BYTE);
  localparam logic        MOSI_IDLE      = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: half-period counter that toggles sclk every div+1 clocks while run is high.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             term;

  // Counter restarts at zero whenever run drops, so a new transfer begins with a full low phase.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    term   = run && (cnt_q == div);
    if (!run) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (term) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  // Pulses flag the cycle whose closing clock edge moves sclk.
  assign sclk       = sclk_q;
  assign rise_pulse = term && !sclk_q;
  assign fall_pulse = term && sclk_q;

endmodule

// File: rtl/spi_shift_engine.sv
// Mode-0 MSB-first SPI master: accepts one byte per start, shifts it out on MOSI and captures MISO.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             start,
  input  logic [7:0]       tx_data,
  input  logic [DIV_W-1:0] div,
  input  logic             miso,
  output logic             mosi,
  output logic             sclk,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_data
);

  state_e              state_q, state_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                run, rise_pulse, fall_pulse;

  assign run = (state_q == ST_SHIFT);

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk        (clk),
    ._reset     (_reset),
    .run        (run),
    .div        (div_q),
    .sclk       (sclk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          div_d      = div;
          edge_cnt_d = '0;
          mosi_d     = tx_data[7];
          busy_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise_pulse) begin
          rx_shift_d = {rx_shift_q[6:0], miso};
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        end
        if (fall_pulse) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          mosi_d     = tx_shift_q[6];
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          // Final falling edge closes the byte; start may be taken in the very next (done) cycle.
          if (edge_cnt_q == EDGE_W'(EDGES_PER_BYTE - 1)) begin
            state_d   = ST_IDLE;
            mosi_d    = MOSI_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      div_q      <= '0;
      edge_cnt_q <= '0;
      mosi_q     <= MOSI_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine against a timing-formula reference model.
module tb_spi_shift_engine;

  localparam int unsigned DIV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       tx_data;
  logic [DIV_W-1:0] div;
  logic             miso;
  logic             mosi;
  logic             sclk;
  logic             busy;
  logic             done;
  logic [7:0]       rx_data;

  int               n_cmp;
  int               n_err;
  logic [7:0]       exp_rx;

  spi_shift_engine #(.DIV_W(DIV_W)) dut (
    .clk     (clk),
    ._reset  (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .div     (div),
    .miso    (miso),
    .mosi    (mosi),
    .sclk    (sclk),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sclk"}, 32'(sclk), 32'(0));
    chk({tag, "_mosi"}, 32'(mosi), 32'(1));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_rx"},   32'(rx_data), 32'(exp_rx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_idle("idle");
      start   = 1'b0;
      tx_data = 8'($urandom);
      div     = DIV_W'($urandom);
    end
  endtask

  task automatic drive_start(input logic [7:0] txv, input int d);
    @(negedge clk);
    chk_idle("pre");
    start   = 1'b1;
    tx_data = txv;
    div     = DIV_W'(d);
  endtask

  // Expected waveform after T0: edge k lands at T0+1+k*(d+1); done at k=16.
  task automatic watch(input logic [7:0] txv, input int d, input logic [7:0] rxv,
                       input bit b2b, input logic [7:0] ntx, input int nd,
                       input int abort_k, input int ign_at);
    int  last;
    bit  aborted;
    last    = 1 + 16 * (d + 1);
    aborted = 1'b0;
    for (int o = 1; o <= last && !aborted; o++) begin
      int k;
      @(negedge clk);
      k = (o - 1) / (d + 1);
      if (k < 16) begin
        chk("busy", 32'(busy), 32'(1));
        chk("sclk", 32'(sclk), 32'(k % 2));
        chk("mosi", 32'(mosi), 32'(txv[7 - k / 2]));
        chk("done", 32'(done), 32'(0));
        chk("rx_hold", 32'(rx_data), 32'(exp_rx));
        miso = rxv[7 - k / 2];
      end else begin
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_pulse", 32'(done), 32'(1));
        chk("done_sclk", 32'(sclk), 32'(0));
        chk("done_mosi", 32'(mosi), 32'(1));
        chk("rx_data", 32'(rx_data), 32'(rxv));
        exp_rx = rxv;
      end
      start   = 1'b0;
      tx_data = 8'($urandom);
      div     = DIV_W'($urandom);
      if (o < last && (o == ign_at || $urandom_range(0, 9) == 0)) start = 1'b1;
      if (o == last && b2b) begin
        start   = 1'b1;
        tx_data = ntx;
        div     = DIV_W'(nd);
      end
      if (k == abort_k && ((o - 1) % (d + 1)) == 0) begin
        start  = 1'b0;
        rst_n  = 1'b0;
        #1;
        exp_rx = 8'h00;
        chk_idle("rst_async");
        idle(2);
        rst_n   = 1'b1;
        aborted = 1'b1;
      end
    end
  endtask

  initial begin
    bit         chained;
    bit         nb;
    logic [7:0] cur_tx, ntx, rxv;
    int         cur_d, nd;

    n_cmp   = 0;
    n_err   = 0;
    exp_rx  = 8'h00;
    rst_n   = 1'b0;
    start   = 1'b0;
    tx_data = 8'h00;
    div     = '0;
    miso    = 1'b0;

    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    idle(100);

    // Single byte at div=0
    drive_start(8'hA5, 0);
    watch(8'hA5, 0, 8'h3C, 1'b0, 8'h00, 0, -1, -1);
    idle(3);

    // div=3 with an ignored start at T0+10
    drive_start(8'hFF, 3);
    watch(8'hFF, 3, 8'($urandom), 1'b0, 8'h00, 0, -1, 10);
    idle(5);

    // Back-to-back bytes at div=1
    drive_start(8'h01, 1);
    watch(8'h01, 1, 8'($urandom), 1'b1, 8'h80, 1, -1, -1);
    watch(8'h80, 1, 8'($urandom), 1'b0, 8'h00, 0, -1, -1);
    idle(3);

    // Reset at the 5th sclk edge, then a clean transfer
    drive_start(8'h55, 2);
    watch(8'h55, 2, 8'($urandom), 1'b0, 8'h00, 0, 5, -1);
    idle(5);
    drive_start(8'hC3, 2);
    watch(8'hC3, 2, 8'($urandom), 1'b0, 8'h00, 0, -1, -1);
    idle(2);

    // Maximum divider
    cur_tx = 8'($urandom);
    drive_start(cur_tx, (1 << DIV_W) - 1);
    watch(cur_tx, (1 << DIV_W) - 1, 8'($urandom), 1'b0, 8'h00, 0, -1, -1);
    idle(2);

    // Random transfers with random chaining
    chained = 1'b0;
    cur_tx  = 8'h00;
    cur_d   = 0;
    for (int i = 0; i < 30; i++) begin
      if (!chained) begin
        idle($urandom_range(0, 3));
        cur_tx = 8'($urandom);
        cur_d  = $urandom_range(0, 6);
        drive_start(cur_tx, cur_d);
      end
      nb  = (i < 29) && ($urandom_range(0, 1) == 1);
      ntx = 8'($urandom);
      nd  = $urandom_range(0, 6);
      rxv = 8'($urandom);
      watch(cur_tx, cur_d, rxv, nb, ntx, nd, -1, -1);
      chained = nb;
      cur_tx  = ntx;
      cur_d   = nd;
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
